// File: rtl/mdu_seq.sv
// HI/LO multiply/divide sequencer: fixed-latency busy period, atomic HI/LO commit.
// Define MDU_DIV_EN to build the divider; without it div/divu behave as no-ops.
module mdu_seq #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] prod_s, prod_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

`ifdef MDU_DIV_EN
    logic        b_zero;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;

    // Zero divisor is masked so the datapath never sees an undefined quotient.
    assign b_zero = (B == 32'd0);
    assign quot_s = b_zero ? 32'd0 : $signed(A) / $signed(B);
    assign rem_s  = b_zero ? 32'd0 : $signed(A) % $signed(B);
    assign quot_u = b_zero ? 32'd0 : A / B;
    assign rem_u  = b_zero ? 32'd0 : A % B;
`else
    logic [3:0] div_cycles_unused;
    assign div_cycles_unused = 4'(DIV_CYCLES);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            dz_q     <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    case (Op)
                        OP_MULT: begin
                            res_hi_d = prod_s[63:32];
                            res_lo_d = prod_s[31:0];
                            dz_d     = 1'b0;
                            cnt_d    = 4'(MULT_CYCLES);
                            state_d  = S_RUN;
                        end
                        OP_MULTU: begin
                            res_hi_d = prod_u[63:32];
                            res_lo_d = prod_u[31:0];
                            dz_d     = 1'b0;
                            cnt_d    = 4'(MULT_CYCLES);
                            state_d  = S_RUN;
                        end
`ifdef MDU_DIV_EN
                        OP_DIV: begin
                            res_hi_d = rem_s;
                            res_lo_d = quot_s;
                            dz_d     = b_zero;
                            cnt_d    = 4'(DIV_CYCLES);
                            state_d  = S_RUN;
                        end
                        OP_DIVU: begin
                            res_hi_d = rem_u;
                            res_lo_d = quot_u;
                            dz_d     = b_zero;
                            cnt_d    = 4'(DIV_CYCLES);
                            state_d  = S_RUN;
                        end
`endif
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // Start is deliberately ignored here; only the countdown advances.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                    if (!dz_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed table, corner sequences, randomized ops vs. arithmetic model.
module tb_mdu_seq;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    wire         Busy;
    wire  [31:0] HI;
    wire  [31:0] LO;

    mdu_seq #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .Start(Start),
        .Op   (Op),
        .A    (A),
        .B    (B),
        .Busy (Busy),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t tv[9];

`ifdef MDU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural reference: results from plain integer arithmetic.
    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] hi, input logic [31:0] lo,
                                   output logic [31:0] nhi, output logic [31:0] nlo, output int cyc);
        longint      ps;
        logic [63:0] pu;
        int          sa, sb;
        nhi = hi;
        nlo = lo;
        cyc = 0;
        sa  = $signed(a);
        sb  = $signed(b);
        case (op)
            3'd1: begin
                ps  = longint'(sa) * longint'(sb);
                nhi = ps[63:32];
                nlo = ps[31:0];
                cyc = MC;
            end
            3'd2: begin
                pu  = {32'd0, a} * {32'd0, b};
                nhi = pu[63:32];
                nlo = pu[31:0];
                cyc = MC;
            end
            3'd3: if (DIV_ON) begin
                cyc = DC;
                if (b != 0) begin
                    nlo = sa / sb;
                    nhi = sa % sb;
                end
            end
            3'd4: if (DIV_ON) begin
                cyc = DC;
                if (b != 0) begin
                    nlo = a / b;
                    nhi = a % b;
                end
            end
            3'd5: nhi = a;
            3'd6: nlo = a;
            default: ;
        endcase
    endfunction

    // Issue one op, count busy cycles (optionally injecting an illegal Start), then check commit.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int ecyc, input int inj_at);
        int   cnt;
        logic hold_ok;
        @(negedge clk);
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge clk); #1;
        Start = 1'b0; Op = 3'($urandom); A = $urandom; B = $urandom;
        cnt = 0;
        hold_ok = 1'b1;
        while (Busy === 1'b1 && cnt < 20) begin
            cnt++;
            if (HI !== cur_hi || LO !== cur_lo) hold_ok = 1'b0;
            if (cnt == inj_at) begin
                @(negedge clk);
                Start = 1'b1; Op = 3'd1; A = $urandom; B = $urandom;
                @(posedge clk); #1;
                Start = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk({tag, " busy_cycles"}, 64'(cnt), 64'(ecyc));
        if (ecyc > 0) chk({tag, " hold_during_busy"}, {63'd0, hold_ok}, 64'd1);
        chk({tag, " HI"}, {32'd0, HI}, {32'd0, ehi});
        chk({tag, " LO"}, {32'd0, LO}, {32'd0, elo});
        cur_hi = ehi;
        cur_lo = elo;
    endtask

    initial begin
        logic [31:0] nhi, nlo, ra, rb;
        logic [2:0]  rop;
        int          cyc, inj;

        #1;
        chk("reset Busy", {63'd0, Busy}, 64'd0);
        chk("reset HI", {32'd0, HI}, 64'd0);
        chk("reset LO", {32'd0, LO}, 64'd0);
        #20;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-reset Busy", {63'd0, Busy}, 64'd0);

        tv[0] = '{3'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, MC};
        tv[1] = '{3'd2, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, MC};
        if (DIV_ON) begin
            tv[2] = '{3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
            tv[3] = '{3'd4, 32'd7, 32'd2, 32'd1, 32'd3, DC};
        end else begin
            tv[2] = '{3'd3, 32'hFFFFFFF9, 32'd2, 32'h00000004, 32'hFFFFFFF1, 0};
            tv[3] = '{3'd4, 32'd7, 32'd2, 32'h00000004, 32'hFFFFFFF1, 0};
        end
        tv[4] = '{3'd5, 32'h11, 32'hDEAD, 32'h11, tv[3].lo, 0};
        tv[5] = '{3'd6, 32'h22, 32'hBEEF, 32'h11, 32'h22, 0};
        tv[6] = '{3'd3, 32'h1234, 32'd0, 32'h11, 32'h22, DIV_ON ? DC : 0};
        tv[7] = '{3'd0, 32'h5555, 32'h6666, 32'h11, 32'h22, 0};
        tv[8] = '{3'd7, 32'h7777, 32'h8888, 32'h11, 32'h22, 0};

        for (int i = 0; i < 9; i++)
            run_op($sformatf("tv%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo, tv[i].cyc,
                   (i == 6) ? 3 : -1);

        // Start during a mult busy period must be ignored.
        run_op("ign_start", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12, MC, 2);
        run_op("ign_start_last", 3'd2, 32'd6, 32'd7, 32'd0, 32'd42, MC, MC);

        // Reset in the third busy cycle of a mult.
        run_op("pre_mthi", 3'd5, 32'hAA, 32'd0, 32'hAA, 32'd42, 0, -1);
        run_op("pre_mtlo", 3'd6, 32'hBB, 32'd0, 32'hAA, 32'hBB, 0, -1);
        @(negedge clk);
        Start = 1'b1; Op = 3'd1; A = 32'd3; B = 32'd7;
        @(posedge clk); #1;
        Start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid busy_before", {63'd0, Busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid Busy", {63'd0, Busy}, 64'd0);
        chk("rst_mid HI", {32'd0, HI}, 64'd0);
        chk("rst_mid LO", {32'd0, LO}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_mid no_commit Busy", {63'd0, Busy}, 64'd0);
        chk("rst_mid no_commit HI", {32'd0, HI}, 64'd0);
        chk("rst_mid no_commit LO", {32'd0, LO}, 64'd0);
        cur_hi = 32'd0;
        cur_lo = 32'd0;

        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'd0;
                default: rb = 32'hFFFFFFFF;
            endcase
            if (rop == 3'd3 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : -1;
            ref_op(rop, ra, rb, cur_hi, cur_lo, nhi, nlo, cyc);
            run_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, nhi, nlo, cyc, inj);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Multi-cycle multiply/divide sequencer owning the HI/LO register pair in the E stage of the pipelined MIPS core. It accepts one HI/LO operation per start pulse: mult, multu, div, divu, mthi or mtlo. It models the fixed multi-cycle latency with a down-counter and exposes `Busy`, which the hazard unit combines with `Start` to stall later HI/LO-class instructions in D. Results commit to HI/LO atomically at the end of the operation.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1..15.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `Start`  in  1  E-stage HI/LO instruction valid this cycle.
- `Op`  in  3  operation select, sampled only when `Start`=1:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- `A`  in  32  rs operand, forwarded.
- `B`  in  32  rt operand, forwarded.
- `Busy`  out  1  operation in flight.
- `HI`  out  32  architectural HI register.
- `LO`  out  32  architectural LO register.

## Operation
- States: IDLE and RUN; a 4-bit counter `cnt`; result latches `res_hi`, `res_lo`.
- IDLE, `Start`=1, `Op`=1/2:
  - Compute the 64-bit product (signed for op 1, unsigned for op 2) into `res_hi`/`res_lo`.
  - Load `cnt` = `MULT_CYCLES`; go to RUN.
- IDLE, `Start`=1, `Op`=3/4:
  - Compute quotient into `res_lo` and remainder into `res_hi`.
  - Signed division (op 3) truncates toward zero; the remainder takes the sign of the dividend.
  - Load `cnt` = `DIV_CYCLES`; go to RUN.
- IDLE, `Start`=1, `Op`=5: `HI` <= `A` at this edge; stay IDLE; `Busy` stays 0.
- IDLE, `Start`=1, `Op`=6: `LO` <= `A` at this edge; stay IDLE; `Busy` stays 0.
- IDLE, `Op`=0 or 7, or `Start`=0: no state change.
- RUN: `cnt` decrements each edge.
  - At the edge where `cnt` goes 1 -> 0: `HI` <= `res_hi`, `LO` <= `res_lo`; go to IDLE.
- Divide by zero (`B`=0, op 3/4): the full `DIV_CYCLES` busy period still runs, but HI/LO are left unchanged at commit.
- `Start` in RUN is ignored: no latch, no counter reload, HI/LO untouched. The hazard unit must prevent it; the block tolerates it anyway.
- Operands are sampled only at the start edge. Changes to `A`/`B` during RUN have no effect.
- Reset asserted at any time, including mid-RUN: immediately go to IDLE, `cnt`=0, `HI`=`LO`=0, `Busy`=0, and the in-flight result is discarded.

## Timing
- Reset values: `Busy`=0, `HI`=0, `LO`=0, state IDLE, `cnt`=0.
- `Busy` = (state == RUN), a registered output with no combinational path from `Start`.
- Start sampled at edge k, with N = `MULT_CYCLES` or `DIV_CYCLES`:
  - `Busy`=1 for exactly N cycles, from after edge k through edge k+N.
  - `HI`/`LO` hold new values from edge k+N.
  - A new `Start` is accepted at edge k+N+1 at the earliest.
- mthi/mtlo: `HI`/`LO` visible one cycle after the start edge.
- The hazard unit stalls any HI/LO-class D instruction while (`Start` & `Op` in 1..4) | `Busy`. mfhi/mflo read `HI`/`LO` directly with no bypass.

## Configuration
- Macro `MDU_DIV_EN`.
  - Defined: div/divu behave as specified above.
  - Undefined: no divider is synthesized. `Op` 3/4 are treated as `Op`=0: no busy period, HI/LO unchanged. `DIV_CYCLES` is unused.
- mult/multu/mthi/mtlo are identical in both builds.

## Test plan
- Signed mult: `A`=0xFFFFFFFD, `B`=5, `Op`=1, `Start` at edge k.
  - `Busy` high for 5 cycles.
  - From edge k+5: `HI`=0xFFFFFFFF, `LO`=0xFFFFFFF1.
- Unsigned mult: same operands, `Op`=2 -> `HI`=0x00000004, `LO`=0xFFFFFFF1 after 5 cycles.
- Div and divu (`MDU_DIV_EN` defined):
  - `A`=0xFFFFFFF9, `B`=2, `Op`=3 -> after 10 cycles `LO`=0xFFFFFFFD, `HI`=0xFFFFFFFF.
  - `A`=7, `B`=2, `Op`=4 -> `LO`=3, `HI`=1.
- Divide by zero and ignored start:
  - Preload `HI`=0x11, `LO`=0x22 via mthi/mtlo; then `Op`=3 with `B`=0 -> `Busy` high 10 cycles; `HI`/`LO` stay 0x11/0x22.
  - `Start` with `Op`=1 during that busy period -> ignored; no change to `cnt`, `HI` or `LO`.
- Reset mid-operation: start a mult, then drop `rst_n` in its 3rd busy cycle -> `Busy`=0, `HI`=`LO`=0 immediately, and no later commit.
- Divider compiled out: with `MDU_DIV_EN` undefined, `Op`=4, `A`=7, `B`=2 -> `Busy` never rises; `HI`/`LO` unchanged.
